l1d_cache_wb: RTL and testbench
===============================

Name: l1d_cache_wb

Overview:
- Parametrised successor to the load-only L1 data cache: set-associative, handles both loads and stores.
- Write-back, write-allocate policy, with a dirty bit per line.
- FIFO replacement per set; invalid ways are always filled first.
- Sits between the core load/store unit (valid/ready request, one-cycle response pulse) and main memory (line-granular burst interface, one word per beat).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- OFFSET_BITS, 3, word-offset bits; WORDS = 2^OFFSET_BITS words per line.
- INDEX_BITS, 4, set-index bits; SETS = 2^INDEX_BITS.
- WAYS, 4, associativity; must be a power of 2 and at least 2.
- TAG_W is derived: TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  core request present.
- REQ_READY  out  1  cache can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  ADDR_W  word address: [OFFSET_BITS-1:0] is the word offset.
- REQ_WDATA  in  DATA_W  store data.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_RDATA  out  DATA_W  load data; for a store, echoes the stored word.
- RESP_HIT  out  1  qualifies RESP_VALID: 1 = hit, 0 = serviced by a miss.
- MEM_REQ  out  1  memory line request; held until MEM_ADDR_ACK.
- MEM_WE  out  1  1 = write-back burst, 0 = fill burst.
- MEM_ADDR  out  ADDR_W  line-aligned address (offset bits zero).
- MEM_ADDR_ACK  in  1  memory accepted MEM_ADDR; one-cycle pulse.
- MEM_WDATA  out  DATA_W  write-back beat data.
- MEM_WREADY  in  1  memory consumed the current write beat.
- MEM_RDATA  in  DATA_W  fill beat data.
- MEM_RVALID  in  1  fill beat valid.

Behaviour:
- Reset (asynchronous, active-high):
  - All valid and dirty bits cleared; FIFO pointers set to 0; state goes to IDLE.
  - REQ_READY = 1; every other output = 0.
  - Data and tag arrays are not reset.
  - Reset during a burst aborts it: MEM_REQ drops immediately and no line is installed.
- States: IDLE, LOOKUP, WB_ADDR, WB_DATA, FILL_ADDR, FILL_DATA, RESPOND.
- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID, latch address, write enable and write data, then go to LOOKUP.
  - REQ_READY = 0 in every other state.
- LOOKUP:
  - Tag compare across all ways of the indexed set.
  - Hit: a load returns the word; a store writes the word and sets dirty.
  - On a hit, RESP_VALID = 1 and RESP_HIT = 1 in this cycle, then return to IDLE.
  - Hit latency is 2 cycles from the accept edge to the RESP_VALID cycle.
- Victim selection on a miss:
  - Lowest-numbered invalid way if any exists; otherwise the way at the set's FIFO pointer.
  - Victim valid and dirty: go to WB_ADDR. Otherwise go to FILL_ADDR.
- WB_ADDR:
  - MEM_REQ = 1, MEM_WE = 1, MEM_ADDR = {victim tag, index, 0}.
  - On MEM_ADDR_ACK, go to WB_DATA with beat counter = 0.
- WB_DATA:
  - MEM_WDATA = victim word[beat].
  - Each MEM_WREADY advances the beat counter.
  - After beat WORDS-1, clear dirty and go to FILL_ADDR.
- FILL_ADDR: MEM_REQ = 1, MEM_WE = 0, MEM_ADDR = requested line; on MEM_ADDR_ACK, go to FILL_DATA.
- FILL_DATA:
  - Each MEM_RVALID writes MEM_RDATA into the victim way at word[beat].
  - After beat WORDS-1:
    - Set valid = 1 and write the tag.
    - Store miss: merge REQ_WDATA at the offset and set dirty = 1. Load miss: dirty = 0.
    - Advance the FIFO pointer modulo WAYS only if the victim was already valid (it wraps WAYS-1 -> 0).
    - Go to RESPOND.
- RESPOND: RESP_VALID = 1, RESP_HIT = 0, RESP_RDATA = the requested word (merged data for a store); go to IDLE.
- Beat counter is OFFSET_BITS+1 bits wide so the terminal beat is detected without aliasing.
- Ignored inputs: MEM_RVALID outside FILL_DATA, MEM_WREADY outside WB_DATA, MEM_ADDR_ACK outside the two *_ADDR states.
- MEM_REQ deasserts in the cycle after MEM_ADDR_ACK.
- Only one request is outstanding at a time; REQ_VALID while REQ_READY = 0 is not accepted.
- A store immediately followed by a load to the same word returns the stored data.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning beats 0x100..0x107 → one MEM_REQ with MEM_WE = 0 and MEM_ADDR = 0x40; RESP_RDATA = 0x100; RESP_HIT = 0.
- Repeat the load to 0x0000_0045 → RESP_HIT = 1, RESP_RDATA = 0x105, 2-cycle latency, MEM_REQ never asserted.
- Store 0xDEADBEEF to 0x42, then load 0x42 → both hit; load returns 0xDEADBEEF; line dirty.
- Fill set 0 with 4 lines (addresses 0x000, 0x080, 0x100, 0x180; line 0x000 dirty from a store), then access 0x200 →
  - write-back burst to 0x000 (8 beats, merged data present), then fill from 0x200;
  - next eviction in set 0 targets way 1 (FIFO wrap check after 4 more misses returns to way 0).
- Store miss to 0x300 with WDATA 0xA5A5A5A5 → fill, merge at offset 0, RESP_VALID with 0xA5A5A5A5; a later load of 0x300 hits.
- Assert RESET during FILL_DATA beat 3 →
  - outputs drop to reset values in the same cycle;
  - a later load to that address misses again;
  - stray MEM_RVALID beats after reset are ignored.

Source files
------------

// File: rtl/l1d_cache_wb.sv
// Write-back, write-allocate set-associative L1 data cache with per-set FIFO replacement.
// The core side is a valid/ready request with a one-cycle response; the memory side uses line bursts.
module l1d_cache_wb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OFFSET_BITS = 3,
  parameter int INDEX_BITS  = 4,
  parameter int WAYS        = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_hit,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_addr_ack,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_wready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid
);
  localparam int TAG_W    = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAY_BITS = $clog2(WAYS);
  localparam logic [OFFSET_BITS:0] LAST_BEAT = (OFFSET_BITS+1)'(WORDS - 1);
  localparam logic [OFFSET_BITS:0] BEAT_ONE  = (OFFSET_BITS+1)'(1);
  localparam logic [WAY_BITS-1:0]  WAY_ONE   = WAY_BITS'(1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_ADDR, WB_DATA, FILL_ADDR, FILL_DATA, RESPOND
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0]             r_data [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]              r_tag  [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0]     r_valid;
  logic [SETS-1:0][WAYS-1:0]     r_dirty;
  logic [SETS-1:0][WAY_BITS-1:0] r_fifo;

  logic [ADDR_W-1:0]    r_addr;
  logic                 r_we;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic [WAY_BITS-1:0]  r_victim;
  logic                 r_victim_valid;
  logic [OFFSET_BITS:0] r_beat;

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [OFFSET_BITS-1:0] w_beat_off;
  logic                   w_hit;
  logic [WAY_BITS-1:0]    w_hit_way;
  logic                   w_inv_found;
  logic [WAY_BITS-1:0]    w_inv_way;
  logic [WAY_BITS-1:0]    w_way;
  logic [WAY_BITS-1:0]    w_victim;
  logic                   w_victim_dirty;
  logic [DATA_W-1:0]      w_fill_word;

  assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
  assign w_index    = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_offset   = r_addr[OFFSET_BITS-1:0];
  assign w_beat_off = r_beat[OFFSET_BITS-1:0];

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_way       = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_way = WAY_BITS'(w);
      if (r_valid[w_index][w_way] && (r_tag[w_way][w_index] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = w_way;
      end
      if (!r_valid[w_index][w_way] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = w_way;
      end
    end
  end

  // Invalid ways are preferred so the FIFO pointer only rotates over full sets.
  assign w_victim       = w_inv_found ? w_inv_way : r_fifo[w_index];
  assign w_victim_dirty = r_valid[w_index][w_victim] & r_dirty[w_index][w_victim];
  assign w_fill_word    = (r_we && (w_beat_off == w_offset)) ? r_wdata : i_mem_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_rdata = '0;
    o_resp_hit   = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          o_resp_valid = 1'b1;
          o_resp_hit   = 1'b1;
          o_resp_rdata = r_we ? r_wdata : r_data[w_hit_way][w_index][w_offset];
          w_next       = IDLE;
        end else begin
          w_next = w_victim_dirty ? WB_ADDR : FILL_ADDR;
        end
      end
      WB_ADDR: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = {r_tag[r_victim][w_index], w_index, {OFFSET_BITS{1'b0}}};
        if (i_mem_addr_ack) w_next = WB_DATA;
      end
      WB_DATA: begin
        o_mem_wdata = r_data[r_victim][w_index][w_beat_off];
        if (i_mem_wready && (r_beat == LAST_BEAT)) w_next = FILL_ADDR;
      end
      FILL_ADDR: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {w_tag, w_index, {OFFSET_BITS{1'b0}}};
        if (i_mem_addr_ack) w_next = FILL_DATA;
      end
      FILL_DATA: begin
        if (i_mem_rvalid && (r_beat == LAST_BEAT)) w_next = RESPOND;
      end
      RESPOND: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = r_rdata;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid        <= '0;
      r_dirty        <= '0;
      r_fifo         <= '0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_victim       <= '0;
      r_victim_valid <= 1'b0;
      r_beat         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr  <= i_req_addr;
            r_we    <= i_req_we;
            r_wdata <= i_req_wdata;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (r_we) r_dirty[w_index][w_hit_way] <= 1'b1;
          end else begin
            r_victim       <= w_victim;
            r_victim_valid <= r_valid[w_index][w_victim];
            r_beat         <= '0;
          end
        end
        WB_DATA: begin
          if (i_mem_wready) begin
            if (r_beat == LAST_BEAT) begin
              r_dirty[w_index][r_victim] <= 1'b0;
              r_beat                     <= '0;
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        FILL_DATA: begin
          if (i_mem_rvalid) begin
            if (w_beat_off == w_offset) r_rdata <= w_fill_word;
            if (r_beat == LAST_BEAT) begin
              r_valid[w_index][r_victim] <= 1'b1;
              r_dirty[w_index][r_victim] <= r_we;
              if (r_victim_valid) r_fifo[w_index] <= r_fifo[w_index] + WAY_ONE;
              r_beat <= '0;
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; validity alone decides whether they mean anything.
  always_ff @(posedge i_clk) begin
    if ((r_state == LOOKUP) && w_hit && r_we)
      r_data[w_hit_way][w_index][w_offset] <= r_wdata;
    if ((r_state == FILL_DATA) && i_mem_rvalid) begin
      r_data[r_victim][w_index][w_beat_off] <= w_fill_word;
      if (r_beat == LAST_BEAT) r_tag[r_victim][w_index] <= w_tag;
    end
  end

endmodule

// File: tb/tb_l1d_cache_wb.sv
// Randomised bench for l1d_cache_wb: a program-order golden memory plus a per-set
// FIFO cache model predict hit/miss, write-back traffic and returned data.
module tb_l1d_cache_wb;
  localparam int WORDS = 8;
  localparam int SETS  = 16;
  localparam int WAYS  = 4;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_hit;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic        i_mem_addr_ack;
  logic [31:0] o_mem_wdata;
  logic        i_mem_wready;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rvalid;

  l1d_cache_wb dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_hit(o_resp_hit),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .i_mem_addr_ack(i_mem_addr_ack), .o_mem_wdata(o_mem_wdata), .i_mem_wready(i_mem_wready),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] golden [int];
  logic [31:0] dram [int];

  bit mValid [SETS][WAYS];
  bit mDirty [SETS][WAYS];
  int mTag   [SETS][WAYS];
  int mFifo  [SETS];

  logic        recWe [$];
  logic [31:0] recAddr [$];
  logic [31:0] wbData [$];

  bit rspBusy;
  bit rspWe;
  int rspBeat;
  int rspAddr;
  int abortAfter = -1;
  bit strayMode  = 1'b0;

  logic        lastHit;
  logic [31:0] lastData;

  function automatic logic [31:0] initVal(int a);
    return 32'(a) + 32'h0000_00C0;
  endfunction

  function automatic logic [31:0] goldRead(int a);
    if (golden.exists(a)) return golden[a];
    return initVal(a);
  endfunction

  function automatic logic [31:0] dramRead(int a);
    if (dram.exists(a)) return dram[a];
    return initVal(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: random handshake delays, fills from dram, write-backs land in dram.
  initial begin
    i_mem_addr_ack = 1'b0;
    i_mem_rvalid   = 1'b0;
    i_mem_wready   = 1'b0;
    i_mem_rdata    = '0;
    rspBusy        = 1'b0;
    forever begin
      @(negedge clk);
      i_mem_addr_ack = 1'b0;
      i_mem_rvalid   = 1'b0;
      i_mem_wready   = 1'b0;
      if (rst) begin
        rspBusy = 1'b0;
      end else if (strayMode) begin
        i_mem_addr_ack = 1'b1;
        i_mem_rvalid   = 1'b1;
        i_mem_wready   = 1'b1;
        i_mem_rdata    = $urandom;
      end else if (!rspBusy) begin
        if (o_mem_req && ($urandom_range(0, 2) != 0)) begin
          i_mem_addr_ack = 1'b1;
          rspBusy = 1'b1;
          rspWe   = o_mem_we;
          rspAddr = int'(o_mem_addr);
          rspBeat = 0;
          recWe.push_back(o_mem_we);
          recAddr.push_back(o_mem_addr);
        end
      end else if (rspWe) begin
        if ($urandom_range(0, 2) != 0) begin
          i_mem_wready = 1'b1;
          wbData.push_back(o_mem_wdata);
          dram[rspAddr + rspBeat] = o_mem_wdata;
          rspBeat++;
          if (rspBeat == WORDS) rspBusy = 1'b0;
        end
      end else if (!((abortAfter >= 0) && (rspBeat >= abortAfter)) && ($urandom_range(0, 2) != 0)) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = dramRead(rspAddr + rspBeat);
        rspBeat++;
        if (rspBeat == WORDS) rspBusy = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input bit we, input int addr, input logic [31:0] wdata);
    int set, tag, hitWay, victim, wbLine, n;
    bit expHit, expWb, got;
    logic [31:0] expData;
    set    = (addr >> 3) & (SETS - 1);
    tag    = addr >> 7;
    expHit = 1'b0;
    hitWay = 0;
    victim = -1;
    expWb  = 1'b0;
    wbLine = 0;
    for (int w = 0; w < WAYS; w++)
      if (mValid[set][w] && (mTag[set][w] == tag)) begin
        expHit = 1'b1;
        hitWay = w;
      end
    if (!expHit) begin
      for (int w = 0; w < WAYS; w++)
        if (!mValid[set][w] && (victim < 0)) victim = w;
      if (victim < 0) victim = mFifo[set];
      expWb  = mValid[set][victim] && mDirty[set][victim];
      wbLine = (mTag[set][victim] << 7) | (set << 3);
    end
    expData = we ? wdata : goldRead(addr);

    @(negedge clk);
    recWe.delete();
    recAddr.delete();
    wbData.delete();
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = 32'(addr);
    i_req_wdata = wdata;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (o_resp_valid) begin
        got      = 1'b1;
        lastHit  = o_resp_hit;
        lastData = o_resp_rdata;
        break;
      end
    end
    checkOutput("respSeen", 32'(got), 32'd1);
    if (got) begin
      checkOutput("respHit", 32'(lastHit), 32'(expHit));
      checkOutput("respData", lastData, expData);
      if (expHit) begin
        checkOutput("hitLatency", 32'(n + 1), 32'd2);
        checkOutput("hitNoBurst", 32'(recAddr.size()), 32'd0);
      end else begin
        checkOutput("burstCount", 32'(recAddr.size()), expWb ? 32'd2 : 32'd1);
        if (recAddr.size() == (expWb ? 2 : 1)) begin
          if (expWb) begin
            checkOutput("wbWe", 32'(recWe[0]), 32'd1);
            checkOutput("wbAddr", recAddr[0], 32'(wbLine));
            checkOutput("wbBeats", 32'(wbData.size()), 32'(WORDS));
            if (wbData.size() == WORDS)
              for (int k = 0; k < WORDS; k++)
                checkOutput("wbWord", wbData[k], goldRead(wbLine + k));
          end
          checkOutput("fillWe", 32'(recWe[recWe.size()-1]), 32'd0);
          checkOutput("fillAddr", recAddr[recAddr.size()-1], 32'(addr & ~(WORDS - 1)));
        end
      end
    end

    if (we) golden[addr] = wdata;
    if (expHit) begin
      if (we) mDirty[set][hitWay] = 1'b1;
    end else begin
      if (mValid[set][victim]) mFifo[set] = (mFifo[set] + 1) % WAYS;
      mValid[set][victim] = 1'b1;
      mTag[set][victim]   = tag;
      mDirty[set][victim] = we;
    end
  endtask

  initial begin
    int n, strayBad, tag, idx, off;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    for (int s = 0; s < SETS; s++) begin
      mFifo[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 1'b0;
        mDirty[s][w] = 1'b0;
        mTag[s][w]   = 0;
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstReady", 32'(o_req_ready), 32'd1);
    checkOutput("rstRespValid", 32'(o_resp_valid), 32'd0);
    checkOutput("rstMemReq", 32'(o_mem_req), 32'd0);
    checkOutput("rstMemAddr", o_mem_addr, 32'd0);

    // Reset in the middle of a fill: the line must not be installed.
    abortAfter = 3;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h0000_05C3;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    n = 0;
    while (!(rspBusy && !rspWe && (rspBeat == 3)) && (n < 400)) begin
      @(posedge clk);
      n++;
    end
    checkOutput("abortReached", 32'(n < 400), 32'd1);
    #2;
    checkOutput("abortPreReady", 32'(o_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("abortReady", 32'(o_req_ready), 32'd1);
    checkOutput("abortMemReq", 32'(o_mem_req), 32'd0);
    checkOutput("abortRespValid", 32'(o_resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    abortAfter = -1;
    strayMode  = 1'b1;
    strayBad   = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (!o_req_ready || o_mem_req || o_resp_valid) strayBad++;
    end
    checkOutput("strayIgnored", 32'(strayBad), 32'd0);
    strayMode = 1'b0;
    applyStimulus(1'b0, 32'h0000_05C3, '0);
    checkOutput("abortRemiss", 32'(lastHit), 32'd0);

    applyStimulus(1'b0, 32'h0000_0040, '0);
    checkOutput("firstData", lastData, 32'h0000_0100);
    if (recAddr.size() == 1) checkOutput("firstFillAddr", recAddr[0], 32'h0000_0040);
    applyStimulus(1'b0, 32'h0000_0045, '0);
    checkOutput("repeatHit", 32'(lastHit), 32'd1);
    checkOutput("repeatData", lastData, 32'h0000_0105);
    applyStimulus(1'b1, 32'h0000_0042, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0042, '0);
    checkOutput("storeLoadData", lastData, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 32'h0000_0003, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_0080, '0);
    applyStimulus(1'b0, 32'h0000_0100, '0);
    applyStimulus(1'b0, 32'h0000_0180, '0);
    applyStimulus(1'b0, 32'h0000_0200, '0);
    checkOutput("evictBursts", 32'(recAddr.size()), 32'd2);
    if (recAddr.size() == 2) begin
      checkOutput("evictWbAddr", recAddr[0], 32'h0000_0000);
      checkOutput("evictFillAddr", recAddr[1], 32'h0000_0200);
    end
    if (wbData.size() == WORDS) checkOutput("evictMerged", wbData[3], 32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_0280, '0);
    checkOutput("fifoWay1Clean", 32'(recAddr.size()), 32'd1);
    applyStimulus(1'b1, 32'h0000_0300, 32'hA5A5_A5A5);
    checkOutput("storeMissHit", 32'(lastHit), 32'd0);
    checkOutput("storeMissData", lastData, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 32'h0000_0300, '0);
    checkOutput("storeMissThenHit", 32'(lastHit), 32'd1);
    applyStimulus(1'b0, 32'h0000_0380, '0);
    applyStimulus(1'b0, 32'h0000_0400, '0);
    applyStimulus(1'b0, 32'h0000_0480, '0);
    applyStimulus(1'b0, 32'h0000_0500, '0);

    for (int i = 0; i < 400; i++) begin
      tag = $urandom_range(0, 7);
      idx = $urandom_range(0, 3);
      off = $urandom_range(0, 7);
      applyStimulus(1'($urandom_range(0, 1)), (tag << 7) | (idx << 3) | off, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
